// File: rtl/cp_inserter.sv
// cp_inserter: OFDM transmit cyclic-prefix inserter.
// Buffers one IFFT symbol per ping-pong RAM half and replays it
// with its last cp samples prepended (long CP on symbols 0 and 7).
// Ports:
//   clk_i, reset_ni        clock, async active-low reset
//   s_axis_in_*            IFFT samples in (tdata/tvalid/tlast/tready)
//   m_axis_out_*           CP+symbol out (tdata/tvalid/tready/tlast/tuser)
//   tlast_err_o            one-cycle pulse on input framing mismatch
module cp_inserter #(
  parameter int IN_DW = 32,
  parameter int NFFT  = 8
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [IN_DW-1:0] s_axis_in_tdata,
  input  logic             s_axis_in_tvalid,
  input  logic             s_axis_in_tlast,
  output logic             s_axis_in_tready,
  output logic [IN_DW-1:0] m_axis_out_tdata,
  output logic             m_axis_out_tvalid,
  input  logic             m_axis_out_tready,
  output logic             m_axis_out_tlast,
  output logic [3:0]       m_axis_out_tuser,
  output logic             tlast_err_o
);

  localparam int FFT_LEN      = 1 << NFFT;
  localparam int CP_LONG      = 20 * FFT_LEN / 256;
  localparam int CP_SHORT     = 18 * FFT_LEN / 256;
  localparam int SYM_PER_SLOT = 14;

  localparam logic [NFFT-1:0] A_LAST  = NFFT'(FFT_LEN - 1);
  localparam logic [NFFT-1:0] A_LONG  = NFFT'(FFT_LEN - CP_LONG);
  localparam logic [NFFT-1:0] A_SHORT = NFFT'(FFT_LEN - CP_SHORT);
  localparam logic [3:0]      SYM_LAST = 4'(SYM_PER_SLOT - 1);

  typedef enum logic [1:0] {B_FREE, B_FULL, B_READ} buf_t;
  typedef enum logic [1:0] {S_IDLE, S_CP, S_BODY} st_t;

  // First CP address; the address counter then wraps through
  // FFT_LEN-1 -> 0 straight into the body.
  function automatic logic [NFFT-1:0] cp_start(
    input logic [3:0] s
  );
    return (s == 4'd0 || s == 4'd7) ? A_LONG : A_SHORT;
  endfunction

  // ---------------- input side ----------------
  buf_t            r_bst [2];
  logic            r_wptr;
  logic [NFFT-1:0] r_wcnt;
  logic            r_err;
  logic            w_in_rdy;
  logic            w_in_hs;
  logic            w_wlast;

  assign w_in_rdy = (r_bst[r_wptr] == B_FREE);
  assign w_in_hs  = s_axis_in_tvalid && w_in_rdy;
  assign w_wlast  = (r_wcnt == A_LAST);

  assign s_axis_in_tready = w_in_rdy;
  assign tlast_err_o      = r_err;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wptr <= 1'b0;
      r_wcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_in_hs && (s_axis_in_tlast != w_wlast);
      if (w_in_hs) begin
        r_wcnt <= r_wcnt + 1'b1;
        if (w_wlast) r_wptr <= ~r_wptr;
      end
    end
  end

  // ---------------- read FSM ----------------
  st_t             r_state;
  st_t             w_nstate;
  logic [NFFT-1:0] r_addr;
  logic [NFFT-1:0] w_naddr;
  logic            r_rptr;
  logic            w_nrptr;
  logic [3:0]      r_sym;
  logic [3:0]      w_nsym_v;
  logic [3:0]      w_sym_inc;
  logic            w_iss;
  logic [NFFT-1:0] w_iaddr;
  logic            w_ilast;
  logic            w_start;
  logic            w_sbuf;

  // pipeline / skid buffer
  logic             r_pend;
  logic             r_plast;
  logic [3:0]       r_psym;
  logic [IN_DW-1:0] r_rdata;
  logic [IN_DW-1:0] r_fd [2];
  logic             r_fl [2];
  logic [3:0]       r_fu [2];
  logic             r_fwp;
  logic             r_frp;
  logic [1:0]       r_fcnt;
  logic             r_fptr;
  logic             w_pop;
  logic             w_free;
  logic [2:0]       w_occ;
  logic             w_can;

  assign m_axis_out_tvalid = (r_fcnt != 2'd0);
  assign m_axis_out_tdata  = r_fd[r_frp];
  assign m_axis_out_tlast  = r_fl[r_frp];
  assign m_axis_out_tuser  = r_fu[r_frp];

  assign w_pop  = m_axis_out_tvalid && m_axis_out_tready;
  assign w_free = w_pop && m_axis_out_tlast;

  // Issue a read only if its data is sure to find a skid slot:
  // held entries plus the one in flight, minus this cycle's pop.
  assign w_occ = 3'(r_fcnt) + 3'(r_pend) - 3'(w_pop);
  assign w_can = (w_occ <= 3'd1);

  assign w_sym_inc = (r_sym == SYM_LAST) ? 4'd0 : r_sym + 4'd1;

  always_comb begin
    w_nstate = r_state;
    w_naddr  = r_addr;
    w_nrptr  = r_rptr;
    w_nsym_v = r_sym;
    w_iss    = 1'b0;
    w_iaddr  = r_addr;
    w_ilast  = 1'b0;
    w_start  = 1'b0;
    w_sbuf   = r_rptr;
    unique case (r_state)
      S_IDLE: begin
        if (r_bst[r_rptr] == B_FULL && w_can) begin
          w_iss    = 1'b1;
          w_start  = 1'b1;
          w_iaddr  = cp_start(r_sym);
          w_naddr  = w_iaddr + 1'b1;
          w_nstate = (w_iaddr == A_LAST) ? S_BODY : S_CP;
        end
      end
      S_CP: begin
        if (w_can) begin
          w_iss   = 1'b1;
          w_naddr = r_addr + 1'b1;
          if (r_addr == A_LAST) w_nstate = S_BODY;
        end
      end
      S_BODY: begin
        if (w_can) begin
          w_iss   = 1'b1;
          w_naddr = r_addr + 1'b1;
          if (r_addr == A_LAST) begin
            w_ilast  = 1'b1;
            w_nrptr  = ~r_rptr;
            w_nsym_v = w_sym_inc;
            // Chain straight into the next symbol's CP.
            if (r_bst[~r_rptr] == B_FULL) begin
              w_start  = 1'b1;
              w_sbuf   = ~r_rptr;
              w_naddr  = cp_start(w_sym_inc);
              w_nstate = S_CP;
            end else begin
              w_nstate = S_IDLE;
            end
          end
        end
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // RAM: write port from input, registered read port.
  logic [IN_DW-1:0] r_mem [2*FFT_LEN];

  always_ff @(posedge clk_i) begin
    if (w_in_hs) r_mem[{r_wptr, r_wcnt}] <= s_axis_in_tdata;
    if (w_iss)   r_rdata <= r_mem[{r_rptr, w_iaddr}];
  end

  // Buffer ownership. The three events always hit distinct
  // buffers: a FREE one fills, a FULL one starts, a READ one frees.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_bst[0] <= B_FREE;
      r_bst[1] <= B_FREE;
    end else begin
      if (w_in_hs && w_wlast) r_bst[r_wptr] <= B_FULL;
      if (w_start)            r_bst[w_sbuf] <= B_READ;
      if (w_free)             r_bst[r_fptr] <= B_FREE;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rptr  <= 1'b0;
      r_sym   <= 4'd0;
      r_fptr  <= 1'b0;
      r_pend  <= 1'b0;
      r_plast <= 1'b0;
      r_psym  <= 4'd0;
    end else begin
      r_state <= w_nstate;
      r_addr  <= w_naddr;
      r_rptr  <= w_nrptr;
      r_sym   <= w_nsym_v;
      r_pend  <= w_iss;
      r_plast <= w_ilast;
      r_psym  <= r_sym;
      if (w_free) r_fptr <= ~r_fptr;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_fd[0] <= '0;
      r_fd[1] <= '0;
      r_fl[0] <= 1'b0;
      r_fl[1] <= 1'b0;
      r_fu[0] <= 4'd0;
      r_fu[1] <= 4'd0;
      r_fwp   <= 1'b0;
      r_frp   <= 1'b0;
      r_fcnt  <= 2'd0;
    end else begin
      if (r_pend) begin
        r_fd[r_fwp] <= r_rdata;
        r_fl[r_fwp] <= r_plast;
        r_fu[r_fwp] <= r_psym;
        r_fwp       <= ~r_fwp;
      end
      if (w_pop) r_frp <= ~r_frp;
      r_fcnt <= r_fcnt + 2'(r_pend) - 2'(w_pop);
    end
  end

endmodule

// File: tb/tb_cp_inserter.sv
// tb_cp_inserter: self-checking bench for cp_inserter.
// Reference model rebuilds each output symbol from written samples.
module tb_cp_inserter;

  logic        clk;
  logic        reset_ni;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  m_user;
  logic        err;

  cp_inserter #(.IN_DW(32), .NFFT(8)) dut (
    .clk_i             (clk),
    .reset_ni          (reset_ni),
    .s_axis_in_tdata   (s_data),
    .s_axis_in_tvalid  (s_valid),
    .s_axis_in_tlast   (s_last),
    .s_axis_in_tready  (s_ready),
    .m_axis_out_tdata  (m_data),
    .m_axis_out_tvalid (m_valid),
    .m_axis_out_tready (m_ready),
    .m_axis_out_tlast  (m_last),
    .m_axis_out_tuser  (m_user),
    .tlast_err_o       (err)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic [3:0]  u;
  } smp_t;

  typedef struct {
    int          len;
    logic [31:0] first;
    logic [3:0]  user;
    logic [31:0] lastd;
    int          cyc;
    int          tot;
  } st_t;

  typedef struct {
    int          k;
    int          exp_len;
    logic [31:0] exp_first;
    logic [3:0]  exp_user;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int out_pct = 100;

  smp_t        expq[$];
  st_t         stats[$];
  logic [31:0] cur_in [256];
  int          b_wcnt;
  int          m_sym;
  int          pending;
  bit          err_prev;
  int          err_cnt;
  bit          stall_prev;
  smp_t        stall_s;
  int          stall_seen;
  int          cur_idx;
  logic [31:0] cur_first;
  logic [3:0]  cur_user;
  int          tot_out;
  int          t_in_done;
  int          t_first_valid;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_ready = ($urandom_range(99) < out_pct);
    end
  end

  task automatic clear_model();
    expq.delete();
    stats.delete();
    b_wcnt        = 0;
    m_sym         = 0;
    pending       = 0;
    err_prev      = 0;
    err_cnt       = 0;
    stall_prev    = 0;
    stall_seen    = 0;
    cur_idx       = 0;
    cur_first     = '0;
    cur_user      = '0;
    tot_out       = 0;
    t_in_done     = -1;
    t_first_valid = -1;
  endtask

  // Monitor: handshakes seen here complete at the next posedge.
  always @(negedge clk) begin
    if (reset_ni) begin
      bit   mism;
      smp_t e;
      int   cp;
      chk("in_tready", 64'(s_ready), 64'(pending < 2));
      if (pending == 2 && !s_ready) stall_seen++;
      if (err_prev || err) chk("tlast_err", 64'(err), 64'(err_prev));
      if (err) err_cnt++;
      if (stall_prev) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", 64'(m_data), 64'(stall_s.d));
        chk("stall_last", 64'(m_last), 64'(stall_s.l));
        chk("stall_user", 64'(m_user), 64'(stall_s.u));
      end
      stall_prev = m_valid && !m_ready;
      stall_s    = '{m_data, m_last, m_user};
      if (m_valid && t_first_valid < 0) t_first_valid = cyc;
      mism = 0;
      if (s_valid && s_ready) begin
        mism = (s_last != (b_wcnt == 255));
        cur_in[b_wcnt] = s_data;
        b_wcnt++;
        if (b_wcnt == 256) begin
          cp = (m_sym == 0 || m_sym == 7) ? 20 : 18;
          for (int j = 256 - cp; j < 256; j++)
            expq.push_back('{cur_in[j], 1'b0, 4'(m_sym)});
          for (int j = 0; j < 256; j++)
            expq.push_back('{cur_in[j], j == 255, 4'(m_sym)});
          m_sym     = (m_sym + 1) % 14;
          pending   = pending + 1;
          b_wcnt    = 0;
          t_in_done = cyc + 1;
        end
      end
      err_prev = mism;
      if (m_valid && m_ready) begin
        if (expq.size() == 0) begin
          chk("out_unexpected", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("out_data", 64'(m_data), 64'(e.d));
          chk("out_last", 64'(m_last), 64'(e.l));
          chk("out_user", 64'(m_user), 64'(e.u));
        end
        if (cur_idx == 0) cur_first = m_data;
        cur_idx++;
        cur_user = m_user;
        tot_out++;
        if (m_last) begin
          stats.push_back('{cur_idx, cur_first, m_user,
                            m_data, cyc, tot_out});
          cur_idx = 0;
          pending = pending - 1;
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset_ni = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data   = '0;
    #1;
    chk("rst_tready", 64'(s_ready), 64'd1);
    chk("rst_tvalid", 64'(m_valid), 64'd0);
    chk("rst_tlast", 64'(m_last), 64'd0);
    chk("rst_tdata", 64'(m_data), 64'd0);
    chk("rst_tuser", 64'(m_user), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    clear_model();
    repeat (3) @(posedge clk);
    #2;
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // mode 0: tlast on 255; 1: extra tlast on 100; 2: no tlast
  task automatic send_sym(input int k, input int pct,
                          input int mode, input bit rnd);
    int          i;
    int          guard;
    bit          hs;
    logic [31:0] d;
    i     = 0;
    guard = 0;
    d     = rnd ? $urandom : {16'(k), 16'(i)};
    while (i < 256 && guard < 20000) begin
      s_data  = d;
      s_last  = (mode == 1) ? (i == 100 || i == 255) :
                (mode == 2) ? 1'b0 : (i == 255);
      s_valid = ($urandom_range(99) < pct);
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      guard++;
      if (hs) begin
        i++;
        d = rnd ? $urandom : {16'(k), 16'(i)};
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < 256) chk("in_timeout", 64'(i), 64'd256);
  endtask

  task automatic wait_stats(input int n, input int budget);
    for (int c = 0; c < budget && stats.size() < n; c++)
      @(posedge clk);
    #1;
    if (stats.size() < n)
      chk("out_timeout", 64'(stats.size()), 64'(n));
  endtask

  vec_t tbl[15];

  initial begin
    reset_ni = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_data   = '0;
    clear_model();

    for (int k = 0; k < 15; k++) begin
      bit lng;
      lng = ((k % 14) == 0) || ((k % 14) == 7);
      tbl[k] = '{k, lng ? 276 : 274,
                 {16'(k), lng ? 16'd236 : 16'd238},
                 4'(k % 14)};
    end

    // single ramp symbol
    out_pct = 100;
    do_reset();
    send_sym(0, 100, 0, 0);
    wait_stats(1, 2000);
    if (stats.size() >= 1) begin
      chk("t1_len", 64'(stats[0].len), 64'd276);
      chk("t1_first", 64'(stats[0].first), 64'd236);
      chk("t1_lastd", 64'(stats[0].lastd), 64'd255);
      chk("t1_user", 64'(stats[0].user), 64'd0);
    end
    chk("t1_latency", 64'(t_first_valid - t_in_done), 64'd2);
    chk("t1_drained", 64'(expq.size()), 64'd0);

    // 15 back-to-back ramp symbols
    do_reset();
    for (int k = 0; k < 15; k++) send_sym(k, 100, 0, 0);
    wait_stats(15, 6000);
    if (stats.size() >= 15) begin
      for (int k = 0; k < 15; k++) begin
        chk($sformatf("tbl_len[%0d]", k),
            64'(stats[k].len), 64'(tbl[k].exp_len));
        chk($sformatf("tbl_first[%0d]", k),
            64'(stats[k].first), 64'(tbl[k].exp_first));
        chk($sformatf("tbl_user[%0d]", k),
            64'(stats[k].user), 64'(tbl[k].exp_user));
      end
      chk("t2_slot_total", 64'(stats[13].tot), 64'd3840);
      chk("t2_no_bubble",
          64'(stats[14].cyc - stats[0].cyc),
          64'(stats[14].tot - stats[0].tot));
    end
    chk("t2_drained", 64'(expq.size()), 64'd0);

    // random traffic with backpressure
    do_reset();
    out_pct = 50;
    for (int k = 0; k < 6; k++) send_sym(k, 70, 0, 1);
    wait_stats(6, 8000);
    chk("t3_count", 64'(stats.size()), 64'd6);
    chk("t3_in_stalled", 64'(stall_seen > 0), 64'd1);
    chk("t3_drained", 64'(expq.size()), 64'd0);
    out_pct = 100;

    // framing errors
    do_reset();
    send_sym(0, 100, 1, 0);
    send_sym(1, 100, 2, 0);
    wait_stats(2, 2000);
    repeat (2) @(posedge clk);
    #1;
    chk("t4_err_pulses", 64'(err_cnt), 64'd2);
    if (stats.size() >= 2) begin
      chk("t4_len0", 64'(stats[0].len), 64'd276);
      chk("t4_len1", 64'(stats[1].len), 64'd274);
    end

    // reset in the middle of symbol 3 body
    do_reset();
    for (int k = 0; k < 4; k++) send_sym(k, 100, 0, 0);
    for (int c = 0; c < 3000 &&
         !(cur_user == 4'd3 && cur_idx >= 100); c++)
      @(posedge clk);
    chk("t5_reach_sym3", 64'(cur_user == 4'd3 && cur_idx >= 100),
        64'd1);
    do_reset();
    repeat (5) @(posedge clk);
    #1;
    chk("t5_quiet", 64'(m_valid), 64'd0);
    send_sym(9, 100, 0, 0);
    wait_stats(1, 2000);
    if (stats.size() >= 1) begin
      chk("t5_len", 64'(stats[0].len), 64'd276);
      chk("t5_user", 64'(stats[0].user), 64'd0);
      chk("t5_first", 64'(stats[0].first), 64'h000900EC);
    end
    chk("t5_drained", 64'(expq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
